// File: rtl/frame_write_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_ctrl_pkg
// Description : Shared types, default geometry and footer packing for the
//               frame write controller.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_write_ctrl_pkg;

    localparam int c_DEF_BEAT_BYTES   = 4;
    localparam int c_DEF_BLOCK_BYTES  = 64;
    localparam int c_DEF_FOOTER_BYTES = 4;
    localparam int c_DEF_ADDR_W       = 10;
    localparam int c_DEF_LEN_W        = 16;
    localparam int c_FOOTER_LEN_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ALLOC = 2'd2,
        ST_WRITE = 2'd3
    } wr_state_t;

    // Widest-case footer fields; the index is narrowed when packed.
    typedef struct packed {
        logic [23:0]               next_idx;
        logic                      eop;
        logic [c_FOOTER_LEN_W-1:0] len;
    } footer_t;

    function automatic logic [31:0] pack_footer(input footer_t f, input int addr_w);
        logic [31:0] mask;
        mask = (32'd1 << addr_w) - 32'd1;
        return (32'(f.next_idx) & mask)
             | (32'(f.eop) << addr_w)
             | (32'(f.len) << (addr_w + 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_ctrl_if
// Description : Ingress beat, free-list, block-write and frame-report bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_write_ctrl_if
    import frame_write_ctrl_pkg::*;
#(
    parameter int BEAT_BYTES  = c_DEF_BEAT_BYTES,
    parameter int BLOCK_BYTES = c_DEF_BLOCK_BYTES,
    parameter int ADDR_W      = c_DEF_ADDR_W,
    parameter int LEN_W       = c_DEF_LEN_W
);
    localparam int c_BYTES_W = $clog2(BEAT_BYTES) + 1;

    logic [8*BEAT_BYTES-1:0]  data_i;
    logic                     data_valid_i;
    logic                     data_begin_i;
    logic                     data_end_i;
    logic [c_BYTES_W-1:0]     data_bytes_i;
    logic                     data_ready_o;
    logic                     fl_alloc_req_o;
    logic                     fl_alloc_gnt_i;
    logic [ADDR_W-1:0]        fl_alloc_idx_i;
    logic                     mem_we_o;
    logic                     mem_ready_i;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [8*BLOCK_BYTES-1:0] mem_wdata_o;
    logic                     frame_valid_o;
    logic [ADDR_W-1:0]        frame_head_o;
    logic [LEN_W-1:0]         frame_len_o;
    logic                     proto_err_o;

    modport master (
        input  data_i, data_valid_i, data_begin_i, data_end_i, data_bytes_i,
        input  fl_alloc_gnt_i, fl_alloc_idx_i, mem_ready_i,
        output data_ready_o, fl_alloc_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output frame_valid_o, frame_head_o, frame_len_o, proto_err_o
    );

    modport slave (
        output data_i, data_valid_i, data_begin_i, data_end_i, data_bytes_i,
        output fl_alloc_gnt_i, fl_alloc_idx_i, mem_ready_i,
        input  data_ready_o, fl_alloc_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  frame_valid_o, frame_head_o, frame_len_o, proto_err_o
    );

endinterface
`default_nettype wire

// File: rtl/frame_write_ctrl_beat_packer.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_ctrl_beat_packer
// Description : Packs beats into a block payload, first byte at the MSB end.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_write_ctrl_beat_packer #(
    parameter int BEAT_BYTES    = 4,
    parameter int PAYLOAD_BYTES = 60
) (
    input  wire logic                                  clk,
    input  wire logic                                  rst,
    input  wire logic                                  i_start,
    input  wire logic                                  i_load,
    input  wire logic                                  i_clear,
    input  wire logic [8*BEAT_BYTES-1:0]               i_data,
    input  wire logic [$clog2(BEAT_BYTES):0]           i_bytes,
    output logic [8*PAYLOAD_BYTES-1:0]                 o_payload,
    output logic [$clog2(PAYLOAD_BYTES+1)-1:0]         o_byte_cnt,
    output logic                                       o_full
);
    localparam int c_BEAT_BITS    = 8 * BEAT_BYTES;
    localparam int c_PAYLOAD_BITS = 8 * PAYLOAD_BYTES;
    localparam int c_BYTES_W      = $clog2(BEAT_BYTES) + 1;
    localparam int c_CNT_W        = $clog2(PAYLOAD_BYTES + 1);

    logic [c_PAYLOAD_BITS-1:0] r_payload;
    logic [c_CNT_W-1:0]        r_byte_cnt;
    logic [c_BEAT_BITS-1:0]    w_beat_rev;
    logic [c_PAYLOAD_BITS-1:0] w_payload_base;
    logic [c_PAYLOAD_BITS-1:0] w_placed;
    logic [c_CNT_W-1:0]        w_cnt_base;
    logic [c_CNT_W-1:0]        w_cnt_sum;

    // Byte-reverse the beat so its first byte leads; bytes past i_bytes read as zero.
    generate
        for (genvar g = 0; g < BEAT_BYTES; g++) begin : g_beat_byte
            assign w_beat_rev[c_BEAT_BITS-1-8*g -: 8] =
                (c_BYTES_W'(g) < i_bytes) ? i_data[8*g +: 8] : 8'h00;
        end
    endgenerate

    assign w_cnt_base     = i_start ? '0 : r_byte_cnt;
    assign w_cnt_sum      = w_cnt_base + c_CNT_W'(i_bytes);
    assign w_payload_base = i_start ? '0 : r_payload;
    assign w_placed       = {w_beat_rev, {(c_PAYLOAD_BITS-c_BEAT_BITS){1'b0}}} >> {w_cnt_base, 3'b000};

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_payload  <= '0;
            r_byte_cnt <= '0;
        end else if (i_load) begin
            r_payload  <= w_payload_base | w_placed;
            r_byte_cnt <= w_cnt_sum;
        end
    end

    assign o_payload  = r_payload;
    assign o_byte_cnt = r_byte_cnt;
    assign o_full     = (w_cnt_sum == c_CNT_W'(PAYLOAD_BYTES));

endmodule
`default_nettype wire

// File: rtl/frame_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_write_ctrl
// Description : Writes ingress frames into linked buffer blocks and reports
//               each completed frame (head index, byte length).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_write_ctrl
    import frame_write_ctrl_pkg::*;
#(
    parameter int BEAT_BYTES   = c_DEF_BEAT_BYTES,
    parameter int BLOCK_BYTES  = c_DEF_BLOCK_BYTES,
    parameter int FOOTER_BYTES = c_DEF_FOOTER_BYTES,
    parameter int ADDR_W       = c_DEF_ADDR_W,
    parameter int LEN_W        = c_DEF_LEN_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    frame_write_ctrl_if.master bus
);
    localparam int c_PAYLOAD_BYTES = BLOCK_BYTES - FOOTER_BYTES;
    localparam int c_PAYLOAD_BITS  = 8 * c_PAYLOAD_BYTES;
    localparam int c_FOOTER_BITS   = 8 * FOOTER_BYTES;
    localparam int c_BYTES_W       = $clog2(BEAT_BYTES) + 1;
    localparam int c_CNT_W         = $clog2(c_PAYLOAD_BYTES + 1);

    wr_state_t            r_state;
    wr_state_t            w_state_nxt;
    logic [ADDR_W-1:0]    r_spare_idx,   w_spare_idx_nxt;
    logic                 r_spare_valid, w_spare_valid_nxt;
    logic [ADDR_W-1:0]    r_curr_idx,    w_curr_idx_nxt;
    logic [ADDR_W-1:0]    r_head_idx,    w_head_idx_nxt;
    logic [ADDR_W-1:0]    r_next_idx,    w_next_idx_nxt;
    logic                 r_eop,         w_eop_nxt;
    logic [LEN_W-1:0]     r_frame_len,   w_frame_len_nxt;
    logic                 r_data_ready,  w_data_ready_nxt;
    logic                 r_fl_req,      w_fl_req_nxt;
    logic                 r_frame_valid, w_frame_valid_nxt;
    logic                 r_proto_err,   w_proto_err_nxt;
    logic [ADDR_W-1:0]    r_frame_head;
    logic [LEN_W-1:0]     r_frame_len_rpt;

    logic                      w_beat_fire;
    logic                      w_gnt_fire;
    logic [c_BYTES_W-1:0]      w_beat_bytes;
    logic                      w_pack_start;
    logic                      w_pack_load;
    logic                      w_pack_clear;
    logic                      w_pack_full;
    logic [c_PAYLOAD_BITS-1:0] w_payload;
    logic [c_CNT_W-1:0]        w_byte_cnt;
    logic [31:0]               w_footer_word;
    logic [c_FOOTER_BITS-1:0]  w_footer;

    assign w_beat_fire  = bus.data_valid_i && r_data_ready;
    assign w_gnt_fire   = r_fl_req && bus.fl_alloc_gnt_i;
    assign w_beat_bytes = bus.data_end_i ? bus.data_bytes_i : c_BYTES_W'(BEAT_BYTES);

    frame_write_ctrl_beat_packer #(
        .BEAT_BYTES    (BEAT_BYTES),
        .PAYLOAD_BYTES (c_PAYLOAD_BYTES)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_pack_start),
        .i_load     (w_pack_load),
        .i_clear    (w_pack_clear),
        .i_data     (bus.data_i),
        .i_bytes    (w_beat_bytes),
        .o_payload  (w_payload),
        .o_byte_cnt (w_byte_cnt),
        .o_full     (w_pack_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_spare_idx_nxt   = r_spare_idx;
        w_spare_valid_nxt = r_spare_valid;
        w_curr_idx_nxt    = r_curr_idx;
        w_head_idx_nxt    = r_head_idx;
        w_next_idx_nxt    = r_next_idx;
        w_eop_nxt         = r_eop;
        w_frame_len_nxt   = r_frame_len;
        w_frame_valid_nxt = 1'b0;
        w_proto_err_nxt   = 1'b0;
        w_pack_start      = 1'b0;
        w_pack_load       = 1'b0;
        w_pack_clear      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Grant and beat cannot coincide: req needs !spare, ready needs spare.
                if (w_gnt_fire) begin
                    w_spare_idx_nxt   = bus.fl_alloc_idx_i;
                    w_spare_valid_nxt = 1'b1;
                end
                if (w_beat_fire) begin
                    if (bus.data_begin_i) begin
                        w_curr_idx_nxt    = r_spare_idx;
                        w_head_idx_nxt    = r_spare_idx;
                        w_spare_valid_nxt = 1'b0;
                        w_pack_start      = 1'b1;
                        w_pack_load       = 1'b1;
                        w_frame_len_nxt   = LEN_W'(w_beat_bytes);
                        w_next_idx_nxt    = '0;
                        w_eop_nxt         = bus.data_end_i;
                        if (bus.data_end_i) begin
                            w_state_nxt = ST_WRITE;
                        end else if (w_pack_full) begin
                            w_state_nxt = ST_ALLOC;
                        end else begin
                            w_state_nxt = ST_FILL;
                        end
                    end else begin
                        w_proto_err_nxt = 1'b1;
                    end
                end
            end

            ST_FILL: begin
                if (w_beat_fire) begin
                    w_pack_load     = 1'b1;
                    w_frame_len_nxt = r_frame_len + LEN_W'(w_beat_bytes);
                    if (bus.data_end_i) begin
                        w_eop_nxt      = 1'b1;
                        w_next_idx_nxt = '0;
                        w_state_nxt    = ST_WRITE;
                    end else if (w_pack_full) begin
                        w_state_nxt = ST_ALLOC;
                    end
                end
            end

            ST_ALLOC: begin
                if (w_gnt_fire) begin
                    w_next_idx_nxt = bus.fl_alloc_idx_i;
                    w_eop_nxt      = 1'b0;
                    w_state_nxt    = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (bus.mem_ready_i) begin
                    if (r_eop) begin
                        w_frame_valid_nxt = 1'b1;
                        w_state_nxt       = ST_IDLE;
                    end else begin
                        w_curr_idx_nxt = r_next_idx;
                        w_pack_clear   = 1'b1;
                        w_state_nxt    = ST_FILL;
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase

        // Handshake outputs are registered from the upcoming state.
        w_data_ready_nxt = ((w_state_nxt == ST_IDLE) && w_spare_valid_nxt) || (w_state_nxt == ST_FILL);
        w_fl_req_nxt     = ((w_state_nxt == ST_IDLE) && !w_spare_valid_nxt) || (w_state_nxt == ST_ALLOC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spare_idx     <= '0;
            r_spare_valid   <= 1'b0;
            r_curr_idx      <= '0;
            r_head_idx      <= '0;
            r_next_idx      <= '0;
            r_eop           <= 1'b0;
            r_frame_len     <= '0;
            r_data_ready    <= 1'b0;
            r_fl_req        <= 1'b0;
            r_frame_valid   <= 1'b0;
            r_proto_err     <= 1'b0;
            r_frame_head    <= '0;
            r_frame_len_rpt <= '0;
        end else begin
            r_spare_idx   <= w_spare_idx_nxt;
            r_spare_valid <= w_spare_valid_nxt;
            r_curr_idx    <= w_curr_idx_nxt;
            r_head_idx    <= w_head_idx_nxt;
            r_next_idx    <= w_next_idx_nxt;
            r_eop         <= w_eop_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_data_ready  <= w_data_ready_nxt;
            r_fl_req      <= w_fl_req_nxt;
            r_frame_valid <= w_frame_valid_nxt;
            r_proto_err   <= w_proto_err_nxt;
            if (w_frame_valid_nxt) begin
                r_frame_head    <= r_head_idx;
                r_frame_len_rpt <= r_frame_len;
            end
        end
    end

    assign w_footer_word = pack_footer('{next_idx: 24'(r_next_idx),
                                         eop:      r_eop,
                                         len:      c_FOOTER_LEN_W'(w_byte_cnt)}, ADDR_W);
    assign w_footer      = c_FOOTER_BITS'(w_footer_word);

    assign bus.data_ready_o   = r_data_ready;
    assign bus.fl_alloc_req_o = r_fl_req;
    assign bus.mem_we_o       = (r_state == ST_WRITE);
    assign bus.mem_addr_o     = r_curr_idx;
    assign bus.mem_wdata_o    = {w_payload, w_footer};
    assign bus.frame_valid_o  = r_frame_valid;
    assign bus.frame_head_o   = r_frame_head;
    assign bus.frame_len_o    = r_frame_len_rpt;
    assign bus.proto_err_o    = r_proto_err;

endmodule
`default_nettype wire
